// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
//   state_t   : access FSM states (IDLE/REQ/WAIT_R/DONE)
//   size_t    : access width decoded from funct3
//   F3_*      : funct3 encodings for loads/stores
//   size_of() : funct3 -> access width (unlisted encodings fall back to word)
//   be_gen()  : byte-enable pattern for a width at a byte offset
//   wdata_gen(): replicate store data across all byte lanes
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Only the low two funct3 bits select width; 011/110/111 land on word.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Shift result is truncated to 4 bits, so a halfword at offset 3 keeps only lane 3.
  function automatic logic [3:0] be_gen(input size_t sz, input logic [1:0] off);
    logic [3:0] base;
    case (sz)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] wdata_gen(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: shifts the read word down by the byte
// offset, then sign- or zero-extends byte/halfword results.
//   rdata      in  32  raw read word from the data bus
//   offset     in  2   byte offset of the access (addr[1:0])
//   size       in  -   access width
//   is_unsigned in 1   zero-extend (BU/HU) instead of sign-extend
//   data       out 32  extended load result
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_B:    data = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    data = is_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit on a req/gnt/rvalid data-memory bus.
// Generates byte enables and lane-steered store data, extracts and extends
// load data, and stalls the EX/MEM register until the access completes.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds misalign_o and
// suppresses misaligned halfword/word accesses).
//   clk, rst          clock, synchronous active-high reset
//   pc_valid_i        EX/MEM slot holds a real instruction
//   mem_rd_en_i/wr_en load / store
//   mem_ctrl_i        [2:0] funct3, [3] ignored
//   addr_i            effective byte address
//   store_data_i      LSB-justified store data
//   dmem_*            data-memory bus (req held until gnt)
//   load_data_o       extended load result (held until next load)
//   load_valid_o      one-cycle load-complete pulse
//   stall_o           freeze EX/MEM register and upstream
//   misalign_o        misaligned access pulse (MEM_MISALIGN_TRAP_EN only)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid_i,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [3:0]        mem_ctrl_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              stall_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  state_t            state;
  logic              access;
  logic              misal;
  logic              issue;
  size_t             cur_size;
  logic [3:0]        cur_be;
  logic [DATA_W-1:0] cur_wdata;
  logic [ADDR_W-1:0] cur_addr;

  // Fields held while the request waits for gnt and the load for rvalid.
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_wdata;
  size_t             lat_size;
  logic              lat_unsigned;
  logic [1:0]        lat_off;
  logic [DATA_W-1:0] load_data_r;
  logic [DATA_W-1:0] ext_data;

  logic unused_ctrl;
  assign unused_ctrl = mem_ctrl_i[3];

  always_comb begin
    access    = pc_valid_i & (mem_rd_en_i | mem_wr_en_i);
    cur_size  = size_of(mem_ctrl_i[2:0]);
    cur_be    = be_gen(cur_size, addr_i[1:0]);
    cur_wdata = wdata_gen(cur_size, store_data_i);
    cur_addr  = {addr_i[ADDR_W-1:2], 2'b00};
`ifdef MEM_MISALIGN_TRAP_EN
    misal = access & (((cur_size == SZ_H) & addr_i[0]) |
                      ((cur_size == SZ_W) & (addr_i[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
    issue = access & ~misal;
  end

  mem_load_align u_align (
    .rdata       (dmem_rdata_i),
    .offset      (lat_off),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (ext_data)
  );

  // IDLE drives the bus straight from the pipeline so a same-cycle gnt on a
  // store costs no stall; later states replay the latched copy.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = mem_wr_en_i;
          dmem_addr_o  = cur_addr;
          dmem_be_o    = cur_be;
          dmem_wdata_o = cur_wdata;
          stall_o      = ~(dmem_gnt_i & mem_wr_en_i);
        end
      end
      ST_REQ: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = lat_we;
        dmem_addr_o  = lat_addr;
        dmem_be_o    = lat_be;
        dmem_wdata_o = lat_wdata;
        stall_o      = 1'b1;
      end
      ST_WAIT_R: stall_o = 1'b1;
      ST_DONE:   load_valid_o = ~lat_we;
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o = (state == ST_IDLE) & misal;
`endif

  assign load_data_o = load_data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      lat_size     <= SZ_B;
      lat_unsigned <= 1'b0;
      lat_off      <= '0;
      load_data_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            lat_we       <= mem_wr_en_i;
            lat_addr     <= cur_addr;
            lat_be       <= cur_be;
            lat_wdata    <= cur_wdata;
            lat_size     <= cur_size;
            lat_unsigned <= mem_ctrl_i[2];
            lat_off      <= addr_i[1:0];
            if (dmem_gnt_i) state <= mem_wr_en_i ? ST_IDLE : ST_WAIT_R;
            else            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_gnt_i) state <= lat_we ? ST_DONE : ST_WAIT_R;
        end
        ST_WAIT_R: begin
          if (dmem_rvalid_i) begin
            load_data_r <= ext_data;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
